data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, memory depth in 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data, 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned, reserved size or out-of-range access.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-016 SHALL drive rsp_valid high for exactly one cycle, the cycle after acceptance; fixed latency 1; one request per cycle sustainable.
REQ-017 SHALL derive word index = req_addr >> 2 and lane offset = req_addr[1:0].
REQ-018 SHALL flag an error when size 01 with addr[0]=1, size 10 with addr[1:0]!=0, size 11, or word index >= DEPTH.
REQ-019 SHALL, on an erroring request, leave memory untouched and respond with rsp_err=1, rsp_rdata=0.
REQ-020 SHALL, on an accepted store, write only the addressed byte lanes at the acceptance edge: byte -> lane[offset] from wdata[7:0], half -> lanes offset,offset+1 from wdata[15:0], word -> all lanes.
REQ-021 SHALL, on a load, register the addressed word and return the selected byte/half shifted to bit 0, extended per req_unsigned; word loads unaltered.
REQ-022 SHALL return post-write data to a load accepted the cycle after a store to the same word (no stale read).
REQ-023 SHALL implement FSM states INIT and RUN; req_ready=1 only in RUN.
REQ-024 SHALL ignore req_valid while req_ready=0; no request is queued.
REQ-025 SHALL ignore req_unsigned and req_wdata where irrelevant to the operation.

Reset
REQ-026 SHALL on rst_n low asynchronously force rsp_valid=0, rsp_rdata=0, rsp_err=0 and FSM to INIT.
REQ-027 SHALL drop a response pending at reset assertion; a store accepted before reset stays written.
REQ-028 SHALL not reset memory contents through the asynchronous reset path.

Configuration
REQ-029 SHALL honour macro DATA_MEM_CLEAR_ON_RESET_EN.
REQ-030 SHALL, with DATA_MEM_CLEAR_ON_RESET_EN defined, stay in INIT after reset release for DEPTH cycles writing 0 to words 0..DEPTH-1 via an internal counter, then enter RUN.
REQ-031 SHALL, without DATA_MEM_CLEAR_ON_RESET_EN, enter RUN on the first clock edge after reset release and preserve preloaded contents (signature/test images).

Structure
REQ-032 SHALL take size encodings (SIZE_B/H/W) and the 32-bit data width constant from the shared define file.
REQ-033 SHALL place lane selection, store merge and load extension in sub-module data_mem_lane (combinational); storage, FSM and response registers stay in data_mem.

Verification
REQ-034 SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle later.
REQ-035 SHALL cover: SB 0x80 @0x13 over 0x11223344, LB @0x13 -> 0xFFFFFF80, LBU @0x13 -> 0x00000080, LW @0x10 -> 0x80223344.
REQ-036 SHALL cover: SH 0xABCD @0x21 -> rsp_err=1, word 0x20 unchanged; LW @0x22 -> rsp_err=1, rsp_rdata=0.
REQ-037 SHALL cover: LW @(DEPTH*4) -> rsp_err=1; back-to-back SW @0x30 then LW @0x30 on consecutive cycles -> new data returned.
REQ-038 SHALL cover: with DATA_MEM_CLEAR_ON_RESET_EN, req_ready low for DEPTH cycles after reset, then LW @0x40 -> 0; without it, req_ready high on second cycle and preloaded word returned.
REQ-039 SHALL cover: rst_n asserted mid-stream with a load in flight -> rsp_valid never pulses for it, outputs 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data memory block: data width, access-size
// encodings, FSM state encoding and the alignment-check helper.
// No ports (package).
// -----------------------------------------------------------------------------
package data_mem_pkg;

  localparam int unsigned DATA_W = 32;

  // Access size as carried on req_size
  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True when the access cannot be performed at this lane offset
  // (the reserved size is treated as never aligned).
  function automatic logic f_misaligned(input size_e size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = offset[0];
      SIZE_W:  bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_lane.sv
// -----------------------------------------------------------------------------
// data_mem_lane
// Combinational byte-lane logic: merges store data into the addressed lanes
// of the current word and extracts/extends load data.
// Ports:
//   i_size     access size
//   i_offset   byte-lane offset inside the word
//   i_unsigned load zero-extends when 1, sign-extends when 0
//   i_wdata    right-aligned store data
//   i_rword    current content of the addressed word
//   o_wword    word to write back (only addressed lanes replaced)
//   o_rdata    load result shifted to bit 0 and extended
// -----------------------------------------------------------------------------
module data_mem_lane
  import data_mem_pkg::*;
(
  input  size_e              i_size,
  input  logic [1:0]         i_offset,
  input  logic               i_unsigned,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [DATA_W-1:0]  i_rword,
  output logic [DATA_W-1:0]  o_wword,
  output logic [DATA_W-1:0]  o_rdata
);

  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_wmask;
  logic [DATA_W-1:0] w_wshift;
  logic [DATA_W-1:0] w_rshift;

  // Lane offset expressed as a bit shift
  assign w_shamt = {i_offset, 3'b000};

  // Build the lane mask and lane-aligned store data
  always_comb begin
    w_wmask  = 32'h0000_0000;
    w_wshift = 32'h0000_0000;
    case (i_size)
      SIZE_B: begin
        w_wmask  = 32'h0000_00FF << w_shamt;
        w_wshift = {24'h00_0000, i_wdata[7:0]} << w_shamt;
      end
      SIZE_H: begin
        w_wmask  = 32'h0000_FFFF << w_shamt;
        w_wshift = {16'h0000, i_wdata[15:0]} << w_shamt;
      end
      SIZE_W: begin
        w_wmask  = 32'hFFFF_FFFF;
        w_wshift = i_wdata;
      end
      default: begin
        w_wmask  = 32'h0000_0000;
        w_wshift = 32'h0000_0000;
      end
    endcase
  end

  assign o_wword  = (w_wshift & w_wmask) | (i_rword & ~w_wmask);
  assign w_rshift = i_rword >> w_shamt;

  // Extend the selected byte/half; words pass through unaltered
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_size)
      SIZE_B: begin
        if (i_unsigned) begin
          o_rdata = {24'h00_0000, w_rshift[7:0]};
        end else begin
          o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
        end
      end
      SIZE_H: begin
        if (i_unsigned) begin
          o_rdata = {16'h0000, w_rshift[15:0]};
        end else begin
          o_rdata = {{16{w_rshift[15]}}, w_rshift[15:0]};
        end
      end
      SIZE_W:  o_rdata = i_rword;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Single-port word-organised data memory with byte/half/word loads and stores,
// fixed one-cycle response latency, and error reporting for misaligned,
// reserved-size and out-of-range accesses.
// Optional feature: define DATA_MEM_CLEAR_ON_RESET_EN to zero every word after
// reset release (block stays in INIT for DEPTH cycles). Without it the block
// enters RUN one edge after reset release and keeps existing contents.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      request present
//   req_ready      request accepted this cycle (RUN state only)
//   req_we         1 = store, 0 = load
//   req_size       00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned   load zero-extends when 1
//   req_addr       byte address
//   req_wdata      right-aligned store data
//   rsp_valid      one-cycle response strobe, cycle after acceptance
//   rsp_rdata      extended load data, 0 for stores and errors
//   rsp_err        misaligned, reserved size or out-of-range
// -----------------------------------------------------------------------------
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Storage is intentionally not reset
  logic [DATA_W-1:0] r_mem [DEPTH];

  state_e r_state;
  state_e w_state_nxt;

  logic                  w_accept;
  logic                  w_err;
  logic                  w_oor;
  logic                  w_wr_en;
  logic                  w_clr_done;
  logic [ADDR_WIDTH-1:0] w_word_full;
  logic [IDX_W-1:0]      w_word_idx;
  logic [1:0]            w_offset;
  size_e                 w_size;
  logic [DATA_W-1:0]     w_rword;
  logic [DATA_W-1:0]     w_wword;
  logic [DATA_W-1:0]     w_load;

  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;

  assign w_size      = size_e'(req_size);
  assign w_offset    = req_addr[1:0];
  assign w_word_full = req_addr >> 2'd2;
  assign w_word_idx  = w_word_full[IDX_W-1:0];
  // Range check uses the full index so high address bits cannot alias
  assign w_oor       = (w_word_full >= ADDR_WIDTH'(DEPTH));
  assign w_err       = w_oor | f_misaligned(w_size, w_offset);
  assign w_accept    = req_valid & req_ready;
  assign w_wr_en     = w_accept & req_we & ~w_err;

  // Asynchronous read of the addressed word; a store accepted on the previous
  // edge is already in the array, so back-to-back store/load sees new data.
  assign w_rword = r_mem[w_word_idx];

  data_mem_lane u_lane (
    .i_size     (w_size),
    .i_offset   (w_offset),
    .i_unsigned (req_unsigned),
    .i_wdata    (req_wdata),
    .i_rword    (w_rword),
    .o_wword    (w_wword),
    .o_rdata    (w_load)
  );

`ifdef DATA_MEM_CLEAR_ON_RESET_EN
  logic [IDX_W-1:0] r_clr_cnt;

  // Clear pointer walks words 0..DEPTH-1 while in INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= {IDX_W{1'b0}};
    end else if (r_state == ST_INIT) begin
      r_clr_cnt <= r_clr_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      r_clr_cnt <= r_clr_cnt;
    end
  end

  assign w_clr_done = (r_clr_cnt == IDX_W'(DEPTH - 1));

  // Memory write port: clearing during INIT, lane-merged stores in RUN
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_clr_cnt] <= {DATA_W{1'b0}};
    end else if (w_wr_en) begin
      r_mem[w_word_idx] <= w_wword;
    end
  end
`else
  assign w_clr_done = 1'b1;

  // Memory write port: lane-merged stores
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_word_idx] <= w_wword;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (w_clr_done) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = 1'b0;
    case (r_state)
      ST_RUN:  req_ready = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Response registers; async reset drops any response still pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      if (w_err || req_we) begin
        r_rsp_rdata <= {DATA_W{1'b0}};
      end else begin
        r_rsp_rdata <= w_load;
      end
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
// Self-checking bench for data_mem: directed cases plus randomized accesses
// compared against a byte-addressed reference model. Honours
// DATA_MEM_CLEAR_ON_RESET_EN when the same macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_data_mem;

  localparam int unsigned TB_DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: plain byte array, little-endian
  logic [7:0] mm [TB_DEPTH*4];

  logic        pend_v = 1'b0;
  logic [31:0] pend_d = 32'h0;
  logic        pend_e = 1'b0;
  string       pend_tag = "none";

  data_mem #(.DEPTH(TB_DEPTH), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Behavioural access: error rules, byte-wise store, arithmetic extension
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] data);
    int unsigned n;
    longint      val;
    n    = 32'd1 << size;
    err  = (size == 2'd3) || ((addr % n) != 0) || ((addr / 4) >= TB_DEPTH);
    data = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < int'(n); i++) mm[addr + i] = 8'(wd >> (8 * i));
      end else begin
        val = 0;
        for (int i = 0; i < int'(n); i++) val += longint'(mm[addr + i]) << (8 * i);
        if (!uns && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
        data = 32'(val);
      end
    end
  endtask

  task automatic check_rsp();
    chk({pend_tag, ".valid"}, 32'(rsp_valid), 32'(pend_v));
    if (pend_v) begin
      chk({pend_tag, ".err"}, 32'(rsp_err), 32'(pend_e));
      chk({pend_tag, ".rdata"}, rsp_rdata, pend_d);
    end
  endtask

  // One request per cycle: check previous response, then drive the next one
  task automatic step(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic lit, input logic [31:0] lit_d, input logic lit_e,
                      input string tag);
    logic        e;
    logic [31:0] d;
    @(negedge clk);
    check_rsp();
    model(we, size, uns, addr, wd, e, d);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    pend_v       = 1'b1;
    pend_e       = lit ? lit_e : e;
    pend_d       = lit ? lit_d : d;
    pend_tag     = tag;
  endtask

  task automatic idle();
    @(negedge clk);
    check_rsp();
    req_valid = 1'b0;
    pend_v    = 1'b0;
    pend_tag  = "idle";
  endtask

  task automatic do_release();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_release", 32'(req_ready), 32'h0);
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
    for (int c = 1; c < int'(TB_DEPTH); c++) begin
      @(negedge clk);
      chk("ready_during_clear", 32'(req_ready), 32'h0);
    end
    for (int b = 0; b < int'(TB_DEPTH * 4); b++) mm[b] = 8'h00;
`endif
    @(negedge clk);
    chk("ready_run", 32'(req_ready), 32'h1);
    chk("no_rsp_while_init", 32'(rsp_valid), 32'h0);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    for (int b = 0; b < int'(TB_DEPTH * 4); b++) mm[b] = 8'h00;

    // Reset state
    @(negedge clk);
    chk("reset.valid", 32'(rsp_valid), 32'h0);
    chk("reset.rdata", rsp_rdata, 32'h0);
    chk("reset.err", 32'(rsp_err), 32'h0);
    chk("reset.ready", 32'(req_ready), 32'h0);
    do_release();

    // Fill every word so later loads compare against known model data
    for (int w = 0; w < int'(TB_DEPTH); w++)
      step(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, 32'h0, 1'b0, "fill");

    // Directed cases
    step(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, "sw_10");
    step(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, "lw_10");
    step(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b1, 32'h0, 1'b0, "sw_10b");
    step(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680, 1'b1, 32'h0, 1'b0, "sb_13");
    step(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, "lb_13");
    step(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0, "lbu_13");
    step(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h80223344, 1'b0, "lw_10_merged");
    step(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, "sw_20");
    step(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000ABCD, 1'b1, 32'h0, 1'b1, "sh_21_misal");
    step(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, "lw_20_untouched");
    step(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0, 1'b1, "lw_22_misal");
    step(1'b0, 2'd2, 1'b0, 32'(TB_DEPTH * 4), 32'h0, 1'b1, 32'h0, 1'b1, "lw_oor");
    step(1'b1, 2'd2, 1'b0, 32'(TB_DEPTH * 4 - 4), 32'h01020304, 1'b1, 32'h0, 1'b0, "sw_last");
    step(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, "rsv_size");
    step(1'b0, 2'd2, 1'b0, 32'(TB_DEPTH * 4 - 4), 32'h0, 1'b1, 32'h01020304, 1'b0, "lw_last");
    step(1'b1, 2'd2, 1'b0, 32'h30, 32'h5A5A1234, 1'b1, 32'h0, 1'b0, "sw_30");
    step(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 32'h5A5A1234, 1'b0, "lw_30_b2b");
    step(1'b1, 2'd1, 1'b0, 32'h32, 32'h7777BEEF, 1'b1, 32'h0, 1'b0, "sh_32");
    step(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0, "lh_32");
    step(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, "lhu_32");
    idle();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'(TB_DEPTH * 4) + 32'($urandom_range(0, 15));
      else a = 32'($urandom_range(0, TB_DEPTH * 4 - 1));
      if ($urandom_range(0, 9) < 7 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      step(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
           1'b0, 32'h0, 1'b0, "rand");
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();

    // Reset with a load in flight; ignored request while not ready
    step(1'b1, 2'd2, 1'b0, 32'h34, 32'h600DF00D, 1'b0, 32'h0, 1'b0, "sw_34_pre_reset");
    step(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 1'b0, 32'h0, 1'b0, "lw_34_in_flight");
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    pend_v    = 1'b0;
    pend_tag  = "reset_drop";
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h34;
    req_wdata = 32'hBAD0BAD0;
    #1;
    chk("midreset.valid", 32'(rsp_valid), 32'h0);
    chk("midreset.rdata", rsp_rdata, 32'h0);
    chk("midreset.err", 32'(rsp_err), 32'h0);
    chk("midreset.ready", 32'(req_ready), 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("midreset.hold_valid", 32'(rsp_valid), 32'h0);
    end
    do_release();
    step(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 1'b0, 32'h0, 1'b0, "lw_34_after_reset");
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
    step(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, "lw_40_cleared");
`else
    step(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, "lw_10_preserved");
`endif
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
